// File: rtl/definitions.sv
// ============================================================================
// Module      : definitions
// Description : Shared fetch-unit types and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package definitions;

    localparam int C_PC_W = 10;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_RUN  = 2'd1,
        F_HALT = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC selection: hold, branch (+/-), increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next
    import definitions::*;
#(
    parameter int PC_W = C_PC_W
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_hold,
    input  logic            i_branch_taken,
    input  logic            i_branch_dir,
    input  logic [7:0]      i_branch_offset,
    output logic [PC_W-1:0] o_pc_next
);

    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_pc_fwd;
    logic [PC_W-1:0] w_pc_bwd;
    logic [PC_W-1:0] w_pc_inc;

    // All arithmetic is PC_W wide so wrap-around is modulo 2^PC_W for free.
    assign w_offset = PC_W'(i_branch_offset);
    assign w_pc_fwd = i_pc + w_offset;
    assign w_pc_bwd = i_pc - w_offset;
    assign w_pc_inc = i_pc + PC_W'(1);

    always_comb begin
        o_pc_next = w_pc_inc;
        if (i_hold) begin
            o_pc_next = i_pc;
        end else if (i_branch_taken) begin
            o_pc_next = i_branch_dir ? w_pc_bwd : w_pc_fwd;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : PC register, fetch FSM and execution cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import definitions::*;
#(
    parameter int PC_W  = C_PC_W,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             init_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchTaken,
    input  logic             BranchDir,
    input  logic [7:0]       BranchTargetRegister,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             InstrValid,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [CNT_W-1:0] r_count;
    logic            w_running;
    logic            w_start_accept;

    assign w_running      = (r_state == F_RUN);
    assign w_start_accept = Start && (r_state != F_RUN);

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .i_pc            (r_pc),
        .i_hold          (Stall | Halt),
        .i_branch_taken  (BranchTaken),
        .i_branch_dir    (BranchDir),
        .i_branch_offset (BranchTargetRegister),
        .o_pc_next       (w_pc_next)
    );

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall outranks Halt, so a stalled halt stays in F_RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            F_IDLE:  if (Start) w_state_next = F_RUN;
            F_RUN:   if (!Stall && Halt) w_state_next = F_HALT;
            F_HALT:  if (Start) w_state_next = F_RUN;
            default: w_state_next = F_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_pc <= '0;
        end else if (w_start_accept) begin
            r_pc <= StartAddr;
        end else if (w_running) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_count <= '0;
        end else if (w_start_accept) begin
            r_count <= '0;
        end else if (w_running && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign ProgCtr    = r_pc;
    assign CycleCount = r_count;
    assign InstrValid = w_running;
    assign Done       = (r_state == F_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        CLK;
    logic        init_n;
    logic        Start;
    logic [9:0]  StartAddr;
    logic        Stall;
    logic        Halt;
    logic        BranchTaken;
    logic        BranchDir;
    logic [7:0]  BranchTargetRegister;
    logic [9:0]  ProgCtr;
    logic        InstrValid;
    logic        Done;
    logic [15:0] CycleCount;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .PC_W  (10),
        .CNT_W (16)
    ) dut (
        .CLK                  (CLK),
        .init_n               (init_n),
        .Start                (Start),
        .StartAddr            (StartAddr),
        .Stall                (Stall),
        .Halt                 (Halt),
        .BranchTaken          (BranchTaken),
        .BranchDir            (BranchDir),
        .BranchTargetRegister (BranchTargetRegister),
        .ProgCtr              (ProgCtr),
        .InstrValid           (InstrValid),
        .Done                 (Done),
        .CycleCount           (CycleCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic branch(input logic dir, input logic [7:0] off);
        BranchTaken          = 1'b1;
        BranchDir            = dir;
        BranchTargetRegister = off;
        step();
        BranchTaken          = 1'b0;
    endtask

    initial begin
        init_n = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0; Halt = 1'b0;
        BranchTaken = 1'b0; BranchDir = 1'b0; BranchTargetRegister = '0;
        #12;
        check("rst_pc",    32'(ProgCtr),    0);
        check("rst_cnt",   32'(CycleCount), 0);
        check("rst_done",  32'(Done),       0);
        check("rst_valid", 32'(InstrValid), 0);
        init_n = 1'b1;
        step();

        // Idle ignores everything but Start
        BranchTaken = 1'b1; BranchTargetRegister = 8'd9;
        step();
        BranchTaken = 1'b0;
        check("idle_pc",    32'(ProgCtr),    0);
        check("idle_valid", 32'(InstrValid), 0);

        Start = 1'b1; StartAddr = 10'd5;
        step();
        Start = 1'b0;
        check("start_pc",    32'(ProgCtr),    5);
        check("start_valid", 32'(InstrValid), 1);
        check("start_cnt",   32'(CycleCount), 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", 32'(ProgCtr), 32'(5 + i));
        end
        check("seq_cnt",   32'(CycleCount), 4);
        check("seq_valid", 32'(InstrValid), 1);

        branch(1'b0, 8'd11);
        check("br_to20", 32'(ProgCtr), 20);
        branch(1'b0, 8'd12);
        check("br_fwd12", 32'(ProgCtr), 32);
        branch(1'b1, 8'd40);
        check("br_bwd_wrap", 32'(ProgCtr), 1016);
        branch(1'b0, 8'd7);
        check("br_to1023", 32'(ProgCtr), 1023);
        step();
        check("inc_wrap", 32'(ProgCtr), 0);
        branch(1'b1, 8'd4);
        check("br_to1020", 32'(ProgCtr), 1020);
        branch(1'b0, 8'd10);
        check("br_fwd_wrap", 32'(ProgCtr), 6);
        step();
        check("inc_to7", 32'(ProgCtr), 7);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(ProgCtr), 7);
        end
        Stall = 1'b0;
        step();
        check("unstall_pc",  32'(ProgCtr),    8);
        check("unstall_cnt", 32'(CycleCount), 16);

        Stall = 1'b1; Halt = 1'b1;
        step();
        check("sh_valid", 32'(InstrValid), 1);
        check("sh_done",  32'(Done),       0);
        check("sh_pc",    32'(ProgCtr),    8);
        Stall = 1'b0;
        step();
        Halt = 1'b0;
        check("halt_done",  32'(Done),       1);
        check("halt_valid", 32'(InstrValid), 0);
        check("halt_pc",    32'(ProgCtr),    8);
        check("halt_cnt",   32'(CycleCount), 18);
        branch(1'b0, 8'd3);
        step();
        check("halt_hold_pc",  32'(ProgCtr),    8);
        check("halt_hold_cnt", 32'(CycleCount), 18);
        check("halt_hold_done", 32'(Done),      1);

        Start = 1'b1; StartAddr = 10'd0;
        step();
        Start = 1'b0;
        check("restart_pc",    32'(ProgCtr),    0);
        check("restart_cnt",   32'(CycleCount), 0);
        check("restart_done",  32'(Done),       0);
        check("restart_valid", 32'(InstrValid), 1);

        branch(1'b0, 8'd200);
        branch(1'b0, 8'd100);
        check("pc300", 32'(ProgCtr), 300);
        branch(1'b0, 8'd0);
        check("br_zero", 32'(ProgCtr), 300);
        #2;
        init_n = 1'b0;
        #1;
        check("arst_pc",    32'(ProgCtr),    0);
        check("arst_cnt",   32'(CycleCount), 0);
        check("arst_valid", 32'(InstrValid), 0);
        check("arst_done",  32'(Done),       0);
        init_n = 1'b1;

        Start = 1'b1; StartAddr = 10'd3;
        step();
        check("start3_pc", 32'(ProgCtr), 3);
        StartAddr = 10'd100;
        step();
        Start = 1'b0;
        check("run_start_ignored", 32'(ProgCtr),    4);
        check("run_start_cnt",     32'(CycleCount), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer for the 8-bit core. Holds the PC that addresses instruction memory, steps it each executing cycle, and resolves taken branches using the register file's branch-target register and branch-direction bit. Sits directly downstream of the register file: it consumes `BranchTargetRegister` and `BranchDir`, and takes branch, halt and stall qualifiers from the decoder. It also provides start/done handshaking to the testbench and counts execution cycles.

## Interface
- `PC_W`, 10: program counter width; instruction memory depth is 2^PC_W.
- `CNT_W`, 16: cycle counter width.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `init_n`  in  1  reset; asynchronous, active-low.
- `Start`  in  1  one-cycle pulse; begins execution at `StartAddr`.
- `StartAddr`  in  PC_W  first instruction address, sampled on the accepted `Start`.
- `Stall`  in  1  freezes the PC because the current instruction needs another cycle.
- `Halt`  in  1  the current instruction is halt.
- `BranchTaken`  in  1  the current instruction is a branch whose condition is met.
- `BranchDir`  in  1  from the register file; 1 = backward (subtract), 0 = forward (add).
- `BranchTargetRegister`  in  8  from the register file; unsigned branch offset magnitude.
- `ProgCtr`  out  PC_W  instruction memory address.
- `InstrValid`  out  1  high when the instruction at `ProgCtr` is executing; core writes are qualified by this signal.
- `Done`  out  1  high while halted.
- `CycleCount`  out  CNT_W  number of non-stalled and stalled RUN cycles since the last accepted `Start`.

## Operation
- States: F_IDLE, F_RUN, F_HALT.
- Reset (async, any state) puts the block in F_IDLE with `ProgCtr`=0, `CycleCount`=0, `Done`=0 and `InstrValid`=0.
- F_IDLE:
  - `Start` → F_RUN, `ProgCtr`←`StartAddr`, `CycleCount`←0.
  - All other inputs are ignored.
- F_RUN: `InstrValid`=1 and `CycleCount` increments every cycle, saturating at all-ones. Each cycle applies the first matching rule:
  1. `Stall`: `ProgCtr` holds and the state is unchanged.
  2. `Halt`: → F_HALT, `ProgCtr` holds.
  3. `BranchTaken`: `ProgCtr`←`ProgCtr` ± zero-extended `BranchTargetRegister`. The sign is − when `BranchDir`=1. The result wraps modulo 2^PC_W.
  4. Otherwise: `ProgCtr`←`ProgCtr`+1, wrapping from 2^PC_W−1 to 0.
- In F_RUN, `Start` is ignored.
- Branch offset 0 is legal and re-executes the same instruction.
- F_HALT:
  - `Done`=1, `InstrValid`=0; `ProgCtr` and `CycleCount` hold.
  - `Start` → F_RUN with `ProgCtr`←`StartAddr`, `CycleCount`←0, `Done`←0.
  - All other inputs are ignored.
- `BranchDir`/`BranchTargetRegister` are sampled only when rule 3 fires. A same-cycle register-file write to the branch register or branch-direction bit affects only the next branch.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- `Start` at edge N: `ProgCtr`=`StartAddr` and `InstrValid`=1 after edge N; the first instruction executes in cycle N+1.
- Next-PC latency is 1 cycle.
- `Halt` at edge N: `Done`=1 and `InstrValid`=0 after edge N.
- `init_n` low clears the block immediately, with no clock needed; deassertion is synchronised externally.

## Structure
- Shared `definitions` package holds:
  - `typedef enum logic [1:0] {F_IDLE, F_RUN, F_HALT} fetch_state_t`
  - the default PC width constant.
- One sub-module, `pc_next`: combinational next-PC computation (increment / forward / backward with wrap, priority mux). It is unit-testable on its own.
- The FSM, PC register and counter stay in `fetch_unit`.

## Test plan
- Reset then `Start` with `StartAddr`=5, no branches, for 4 cycles → `ProgCtr` 5,6,7,8,9; `InstrValid`=1; `CycleCount`=4.
- At PC=20, `BranchTaken`=1, `BranchDir`=0, `BranchTargetRegister`=8'd12 → PC=32. Then at PC=32 with `BranchDir`=1 and target 8'd40 → PC=1016 (wrap below 0).
- At PC=1023, no branch → PC=0. At PC=1020, forward branch by 10 → PC=6.
- `Stall` held 3 cycles at PC=7, then released → PC stays 7 for 3 cycles, then 8; `CycleCount` includes the stalled cycles.
- `Stall` and `Halt` asserted together → state stays F_RUN. Drop `Stall` with `Halt`=1 → `Done`=1, `InstrValid`=0, PC frozen. `Start` with `StartAddr`=0 → F_RUN, PC=0, `CycleCount`=0.
- Assert `init_n`=0 mid-F_RUN at PC=300, between clock edges → outputs clear immediately. `Start` while in F_RUN (PC=3) → ignored, PC=4.
